// File: rtl/io_bus_bridge_pkg.sv
// io_bus_bridge_pkg
// Shared definitions for the CPU data-bus bridge:
//  - the fixed IO register addresses and the DRAM window bounds
//  - region-select codes that are carried from the address cycle to the data cycle
//  - timer register offsets and CTRL bit positions
//  - small decode and byte-lane helpers
package io_bus_bridge_pkg;

  // DRAM window (64 KiB at the bottom of the address space)
  localparam logic [31:0] DRAM_BASE     = 32'h0000_0000;
  localparam logic [31:0] DRAM_LAST     = 32'h0000_FFFF;

  // GPIO block
  localparam logic [31:0] IO_ADDR_SW    = 32'hFFFF_F000;
  localparam logic [31:0] IO_ADDR_LED   = 32'hFFFF_F004;
  localparam logic [31:0] IO_ADDR_SEG   = 32'hFFFF_F008;

  // Timer block (contiguous words CNT..STAT)
  localparam logic [31:0] IO_ADDR_CNT   = 32'hFFFF_F020;
  localparam logic [31:0] IO_ADDR_CMP   = 32'hFFFF_F024;
  localparam logic [31:0] IO_ADDR_CTRL  = 32'hFFFF_F028;
  localparam logic [31:0] IO_ADDR_PRESC = 32'hFFFF_F02C;
  localparam logic [31:0] IO_ADDR_STAT  = 32'hFFFF_F030;

  // Region select, registered at the address edge and used to steer cpu_rd
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DRAM = 2'd1,
    SEL_IO   = 2'd2,
    SEL_ERR  = 2'd3
  } sel_e;

  // Timer word offsets: low three bits of the word address inside the timer block
  localparam logic [2:0] TMR_CNT   = 3'd0;
  localparam logic [2:0] TMR_CMP   = 3'd1;
  localparam logic [2:0] TMR_CTRL  = 3'd2;
  localparam logic [2:0] TMR_PRESC = 3'd3;
  localparam logic [2:0] TMR_STAT  = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IE     = 2;

  // True when a bus word address selects the given register word
  function automatic logic word_hit(input logic [29:0] word, input logic [29:0] reg_word);
    return (word == reg_word);
  endfunction

  // Replace the byte lanes of old_w whose strobe is set with the lanes of new_w
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/io_timer.sv
// io_timer
// Prescaled 32-bit up-counter with compare match, optional reload and a
// sticky write-one-to-clear match flag. CNT/CMP/PRESC accept only full-word
// writes; CTRL and STAT live in byte lane 0.
// Only built into io_bus_bridge when IO_BUS_BRIDGE_TIMER_EN is defined.
module io_timer
  import io_bus_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr,
  input  logic [2:0]  i_addr,
  input  logic [31:0] i_wd,
  input  logic [3:0]  i_strb,
  output logic [31:0] o_rd,
  output logic        o_irq
);

  logic [31:0] r_cnt;
  logic [31:0] r_cmp;
  logic [31:0] r_presc;
  logic [31:0] r_psc;
  logic [2:0]  r_ctrl;
  logic        r_match;

  logic w_full;
  logic w_wr_cnt;
  logic w_wr_cmp;
  logic w_wr_presc;
  logic w_wr_ctrl;
  logic w_clr_match;
  logic w_tick;
  logic w_cnt_eq_cmp;

  assign w_full       = (i_strb == 4'hF);
  assign w_wr_cnt     = i_wr && (i_addr == TMR_CNT)   && w_full;
  assign w_wr_cmp     = i_wr && (i_addr == TMR_CMP)   && w_full;
  assign w_wr_presc   = i_wr && (i_addr == TMR_PRESC) && w_full;
  assign w_wr_ctrl    = i_wr && (i_addr == TMR_CTRL)  && i_strb[0];
  assign w_clr_match  = i_wr && (i_addr == TMR_STAT)  && i_strb[0] && i_wd[0];
  // A PRESC lowered below the running prescaler ticks at once instead of
  // running the prescaler all the way round 2^32.
  assign w_tick       = r_ctrl[CTRL_EN] && (r_psc >= r_presc);
  assign w_cnt_eq_cmp = (r_cnt == r_cmp);

  // Configuration registers: CMP, PRESC, CTRL
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp   <= 32'h0000_0000;
      r_presc <= 32'h0000_0000;
      r_ctrl  <= 3'b000;
    end else begin
      if (w_wr_cmp)   r_cmp   <= i_wd;
      if (w_wr_presc) r_presc <= i_wd;
      if (w_wr_ctrl)  r_ctrl  <= i_wd[2:0];
    end
  end

  // Prescaler: counts 0..PRESC while enabled, frozen otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc <= 32'h0000_0000;
    end else if (r_ctrl[CTRL_EN]) begin
      r_psc <= w_tick ? 32'h0000_0000 : (r_psc + 32'h0000_0001);
    end else begin
      r_psc <= r_psc;
    end
  end

  // Counter: a CPU write outranks both the tick increment and the reload
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 32'h0000_0000;
    end else if (w_wr_cnt) begin
      r_cnt <= i_wd;
    end else if (w_tick) begin
      if (w_cnt_eq_cmp && r_ctrl[CTRL_RELOAD]) r_cnt <= 32'h0000_0000;
      else                                     r_cnt <= r_cnt + 32'h0000_0001;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Match flag: a new match in the same cycle wins over the W1C clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_match <= 1'b0;
    end else if (w_tick && w_cnt_eq_cmp) begin
      r_match <= 1'b1;
    end else if (w_clr_match) begin
      r_match <= 1'b0;
    end else begin
      r_match <= r_match;
    end
  end

  // Register read-back for the bridge's peripheral read word
  always_comb begin
    o_rd = 32'h0000_0000;
    case (i_addr)
      TMR_CNT:   o_rd = r_cnt;
      TMR_CMP:   o_rd = r_cmp;
      TMR_CTRL:  o_rd = {29'h0000_0000, r_ctrl};
      TMR_PRESC: o_rd = r_presc;
      TMR_STAT:  o_rd = {31'h0000_0000, r_match};
      default:   o_rd = 32'h0000_0000;
    endcase
  end

  assign o_irq = r_match & r_ctrl[CTRL_IE];

endmodule

// File: rtl/io_bus_bridge.sv
// io_bus_bridge
// Slave side of the CPU data bus. Decodes each access to DRAM, GPIO
// (switches, LEDs, 7-seg) or the timer and returns read data one cycle after
// the address, lining up with the MEM->WB sample of bus read data.
// Configuration macro: IO_BUS_BRIDGE_TIMER_EN -- when defined the io_timer
// block is instantiated; otherwise the timer words read 0, ignore writes,
// stay mapped, and timer_irq is tied low.
module io_bus_bridge
  import io_bus_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DRAM_AW = 14,
  parameter int SW_W    = 24,
  parameter int LED_W   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W/8-1:0]   cpu_ctrl,
  input  logic [DATA_W-1:0]     cpu_wd,
  input  logic                  cpu_we,
  output logic [DATA_W-1:0]     cpu_rd,
  output logic [DRAM_AW-1:0]    dram_addr,
  output logic [DATA_W-1:0]     dram_wd,
  output logic [DATA_W/8-1:0]   dram_we,
  input  logic [DATA_W-1:0]     dram_rd,
  input  logic [SW_W-1:0]       sw_in,
  output logic [LED_W-1:0]      led_out,
  output logic [31:0]           seg_out,
  output logic                  timer_irq,
  output logic                  bus_err
);

  // Address decode
  logic [29:0]          w_word;
  logic                 w_hit_dram;
  logic                 w_hit_sw;
  logic                 w_hit_led;
  logic                 w_hit_seg;
  logic                 w_hit_timer;
  logic                 w_unused_addr_lsb;

  // Access-cycle state
  sel_e                 w_sel;
  sel_e                 r_sel;
  logic [DATA_W-1:0]    w_io_rd;
  logic [DATA_W-1:0]    r_io_rd;
  logic                 r_bus_err;

  // Peripheral state
  logic [LED_W-1:0]     r_led;
  logic [31:0]          r_seg;
  logic [SW_W-1:0]      r_sw_meta;
  logic [SW_W-1:0]      r_sw_sync;

  // Timer interface
  logic [31:0]          w_timer_rd;
  logic                 w_timer_irq;

  assign w_word            = cpu_addr[31:2];
  assign w_unused_addr_lsb = ^cpu_addr[1:0];

  assign w_hit_dram  = (cpu_addr[ADDR_W-1:DRAM_AW+2] == {(ADDR_W-DRAM_AW-2){1'b0}});
  assign w_hit_sw    = word_hit(w_word, IO_ADDR_SW[31:2]);
  assign w_hit_led   = word_hit(w_word, IO_ADDR_LED[31:2]);
  assign w_hit_seg   = word_hit(w_word, IO_ADDR_SEG[31:2]);
  assign w_hit_timer = (w_word >= IO_ADDR_CNT[31:2]) && (w_word <= IO_ADDR_STAT[31:2]);

`ifdef IO_BUS_BRIDGE_TIMER_EN
  io_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_wr   (cpu_we && w_hit_timer),
    .i_addr (w_word[2:0]),
    .i_wd   (cpu_wd),
    .i_strb (cpu_ctrl),
    .o_rd   (w_timer_rd),
    .o_irq  (w_timer_irq)
  );
`else
  // Timer window stays mapped but is inert
  assign w_timer_rd  = 32'h0000_0000;
  assign w_timer_irq = 1'b0;
`endif

  // Region select and peripheral read word for the current address
  always_comb begin
    w_sel   = SEL_ERR;
    w_io_rd = {DATA_W{1'b0}};
    if (w_hit_dram) begin
      w_sel = SEL_DRAM;
    end else if (w_hit_sw) begin
      w_sel   = SEL_IO;
      w_io_rd = {{(DATA_W-SW_W){1'b0}}, r_sw_sync};
    end else if (w_hit_led) begin
      w_sel   = SEL_IO;
      w_io_rd = {{(DATA_W-LED_W){1'b0}}, r_led};
    end else if (w_hit_seg) begin
      w_sel   = SEL_IO;
      w_io_rd = r_seg;
    end else if (w_hit_timer) begin
      w_sel   = SEL_IO;
      w_io_rd = w_timer_rd;
    end else begin
      w_sel   = SEL_ERR;
      w_io_rd = {DATA_W{1'b0}};
    end
  end

  // Address-cycle capture: region, read word and the sticky bus error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel     <= SEL_NONE;
      r_io_rd   <= {DATA_W{1'b0}};
      r_bus_err <= 1'b0;
    end else begin
      r_sel   <= w_sel;
      r_io_rd <= w_io_rd;
      if (w_sel == SEL_ERR) r_bus_err <= 1'b1;
      else                  r_bus_err <= r_bus_err;
    end
  end

  // LED and 7-seg registers, written lane by lane
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= {LED_W{1'b0}};
      r_seg <= 32'h0000_0000;
    end else begin
      if (cpu_we && w_hit_led) begin
        for (int b = 0; b < LED_W/8; b++) begin
          if (cpu_ctrl[b]) r_led[8*b +: 8] <= cpu_wd[8*b +: 8];
        end
      end
      if (cpu_we && w_hit_seg) begin
        r_seg <= lane_merge(r_seg, cpu_wd, cpu_ctrl);
      end
    end
  end

  // Two-flop synchroniser for the asynchronous switches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_meta <= {SW_W{1'b0}};
      r_sw_sync <= {SW_W{1'b0}};
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
    end
  end

  // DRAM is addressed straight from the bus; its own read register gives the latency
  assign dram_addr = cpu_addr[DRAM_AW+1:2];
  assign dram_wd   = cpu_wd;
  assign dram_we   = cpu_ctrl & {(DATA_W/8){cpu_we && w_hit_dram}};

  // Data cycle: DRAM data straight through, everything else from the captured word
  assign cpu_rd    = (r_sel == SEL_DRAM) ? dram_rd : r_io_rd;

  assign led_out   = r_led;
  assign seg_out   = r_seg;
  assign bus_err   = r_bus_err;
  assign timer_irq = w_timer_irq;

endmodule

// File: tb/tb_io_bus_bridge.sv
// tb_io_bus_bridge
// Bench for io_bus_bridge: a behavioural synchronous DRAM on the board side,
// a read scoreboard (expected word queued when the read address is driven,
// compared one cycle later) and direct checks of the side outputs.
// Timer expectations follow IO_BUS_BRIDGE_TIMER_EN.
module tb_io_bus_bridge;

  localparam logic [31:0] A_SW    = 32'hFFFF_F000;
  localparam logic [31:0] A_LED   = 32'hFFFF_F004;
  localparam logic [31:0] A_SEG   = 32'hFFFF_F008;
  localparam logic [31:0] A_CNT   = 32'hFFFF_F020;
  localparam logic [31:0] A_CMP   = 32'hFFFF_F024;
  localparam logic [31:0] A_CTRL  = 32'hFFFF_F028;
  localparam logic [31:0] A_PRESC = 32'hFFFF_F02C;
  localparam logic [31:0] A_STAT  = 32'hFFFF_F030;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_ctrl;
  logic [31:0] cpu_wd;
  logic        cpu_we;
  logic [31:0] cpu_rd;
  logic [13:0] dram_addr;
  logic [31:0] dram_wd;
  logic [3:0]  dram_we;
  logic [31:0] dram_rd;
  logic [23:0] sw_in;
  logic [23:0] led_out;
  logic [31:0] seg_out;
  logic        timer_irq;
  logic        bus_err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  logic [31:0] mem [0:16383];

  io_bus_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_ctrl  (cpu_ctrl),
    .cpu_wd    (cpu_wd),
    .cpu_we    (cpu_we),
    .cpu_rd    (cpu_rd),
    .dram_addr (dram_addr),
    .dram_wd   (dram_wd),
    .dram_we   (dram_we),
    .dram_rd   (dram_rd),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .seg_out   (seg_out),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  // Board DRAM: byte-lane writes, registered read with one cycle latency
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (dram_we[b]) mem[dram_addr][8*b +: 8] <= dram_wd[8*b +: 8];
    end
    dram_rd <= mem[dram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // One bus cycle: retire the previous read from the scoreboard, then drive the next access
  task automatic bus(input logic [31:0] a, input logic [3:0] c, input logic [31:0] d,
                     input logic w, input bit is_rd, input logic [31:0] e, input string tag);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      check_eq(tag_q.pop_front(), cpu_rd, exp_q.pop_front());
    end
    cpu_addr = a;
    cpu_ctrl = c;
    cpu_wd   = d;
    cpu_we   = w;
    if (is_rd) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] c, input logic [31:0] d);
    bus(a, c, d, 1'b1, 1'b0, 32'h0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    bus(a, 4'h0, 32'h0, 1'b0, 1'b1, e, tag);
  endtask

  task automatic idle();
    bus(32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, "");
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    rst      = 1'b1;
    cpu_addr = 32'h0;
    cpu_ctrl = 4'h0;
    cpu_wd   = 32'h0;
    cpu_we   = 1'b0;
    sw_in    = 24'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cpu_rd", cpu_rd, 32'h0);
    check_eq("rst_led", {8'h0, led_out}, 32'h0);
    check_eq("rst_seg", seg_out, 32'h0);
    check_eq("rst_bus_err", {31'h0, bus_err}, 32'h0);
    check_eq("rst_irq", {31'h0, timer_irq}, 32'h0);
    rst = 1'b0;

    // DRAM full write, read-back one cycle after the address
    wr(32'h0000_0010, 4'hF, 32'h1234_5678);
    #1;
    check_eq("dram_we_full", {28'h0, dram_we}, 32'hF);
    check_eq("dram_addr", {18'h0, dram_addr}, 32'h4);
    check_eq("dram_wd", dram_wd, 32'h1234_5678);
    rd(32'h0000_0010, 32'h1234_5678, "dram_rd");
    // DRAM partial write, lanes 0 and 2
    wr(32'h0000_0010, 4'h5, 32'hAABB_CCDD);
    rd(32'h0000_0010, 32'h12BB_56DD, "dram_partial");
    // Top word of the DRAM window
    wr(32'h0000_FFFC, 4'hF, 32'hCAFE_F00D);
    #1;
    check_eq("dram_addr_top", {18'h0, dram_addr}, 32'h3FFF);
    rd(32'h0000_FFFC, 32'hCAFE_F00D, "dram_top");

    // LED: lane 0 update over an existing value, DRAM untouched
    wr(A_LED, 4'hF, 32'h00FF_FF00);
    wr(A_LED, 4'h1, 32'h0000_00AB);
    #1;
    check_eq("led_dram_we", {28'h0, dram_we}, 32'h0);
    idle();
    check_eq("led_out", {8'h0, led_out}, 32'h00FF_FFAB);
    rd(A_LED, 32'h00FF_FFAB, "led_rd");

    // 7-seg: full write then lane 3 only
    wr(A_SEG, 4'hF, 32'hDEAD_BEEF);
    wr(A_SEG, 4'h8, 32'h1122_3344);
    rd(A_SEG, 32'h11AD_BEEF, "seg_rd");
    idle();
    check_eq("seg_out", seg_out, 32'h11AD_BEEF);

    // Switches through the synchroniser
    rd(A_SW, 32'h0, "sw_rd_zero");
    sw_in = 24'h00A5A5;
    idle();
    idle();
    rd(A_SW, 32'h0000_A5A5, "sw_rd");

`ifdef IO_BUS_BRIDGE_TIMER_EN
    // Prescaled compare with reload: match on the third tick, 12 cycles after enable
    wr(A_CMP, 4'hF, 32'd2);
    wr(A_PRESC, 4'hF, 32'd3);
    wr(A_CMP, 4'h1, 32'd9);
    rd(A_CMP, 32'd2, "cmp_partial_ignored");
    wr(A_CTRL, 4'h1, 32'h7);
    repeat (12) idle();
    check_eq("irq_before_match", {31'h0, timer_irq}, 32'h0);
    idle();
    check_eq("irq_at_match", {31'h0, timer_irq}, 32'h1);
    rd(A_CNT, 32'h0, "cnt_reloaded");
    wr(A_STAT, 4'h1, 32'h1);
    idle();
    check_eq("irq_w1c", {31'h0, timer_irq}, 32'h0);
    rd(A_STAT, 32'h0, "stat_cleared");

    // CPU write to CNT on a matching tick: write wins, match still sets
    wr(A_CTRL, 4'h1, 32'h0);
    wr(A_STAT, 4'h1, 32'h1);
    wr(A_PRESC, 4'hF, 32'h0);
    wr(A_CMP, 4'hF, 32'h5);
    wr(A_CNT, 4'hF, 32'h5);
    wr(A_CTRL, 4'h1, 32'h3);
    wr(A_CNT, 4'hF, 32'h50);
    wr(A_CTRL, 4'h1, 32'h0);
    rd(A_CNT, 32'h51, "cnt_write_wins");
    rd(A_STAT, 32'h1, "stat_match_set");
    idle();
    idle();
    rd(A_CNT, 32'h51, "cnt_frozen");
    check_eq("irq_ie_off", {31'h0, timer_irq}, 32'h0);
`else
    // Timer removed: mapped, inert, reads zero
    wr(A_CTRL, 4'h1, 32'h7);
    wr(A_CNT, 4'hF, 32'h50);
    wr(A_PRESC, 4'hF, 32'h0);
    rd(A_CNT, 32'h0, "notimer_cnt");
    rd(A_CTRL, 32'h0, "notimer_ctrl");
    rd(A_STAT, 32'h0, "notimer_stat");
    idle();
    check_eq("notimer_irq", {31'h0, timer_irq}, 32'h0);
`endif
    idle();
    check_eq("bus_err_mapped", {31'h0, bus_err}, 32'h0);

    // Unmapped accesses: zero read data, sticky error, no write side effects
    rd(32'h8000_0000, 32'h0, "unmapped_rd");
    idle();
    check_eq("bus_err_set", {31'h0, bus_err}, 32'h1);
    wr(32'hFFFF_F00C, 4'hF, 32'h1234_5678);
    #1;
    check_eq("unmapped_dram_we", {28'h0, dram_we}, 32'h0);
    rd(32'h0001_0000, 32'h0, "past_dram_rd");
    idle();
    idle();
    check_eq("bus_err_held", {31'h0, bus_err}, 32'h1);
    check_eq("led_after_unmapped", {8'h0, led_out}, 32'h00FF_FFAB);
    check_eq("seg_after_unmapped", seg_out, 32'h11AD_BEEF);

    // Reset during a LED read: pending read discarded, error and LEDs cleared
    idle();
    @(negedge clk);
    cpu_addr = A_LED;
    cpu_we   = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_cpu_rd", cpu_rd, 32'h0);
    check_eq("rst_mid_bus_err", {31'h0, bus_err}, 32'h0);
    check_eq("rst_mid_led", {8'h0, led_out}, 32'h0);
    rst      = 1'b0;
    cpu_addr = 32'h0;
    rd(A_LED, 32'h0, "led_after_rst");
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
